ring_output_arbiter: RTL and testbench

- Downstream consumer of two depth-1 input buffers: the ring pass-through buffer and the local PE injection buffer.
- Arbitrates between the two buffers and issues a one-cycle read enable to the winner.
- Captures the buffer's registered read data and drives one outgoing ring link with a send/ready handshake.
- One instance per router output direction (clockwise and counter-clockwise).

---
 rtl/ring_output_arbiter.sv | 96 +++++++++
 tb/tb_ring_output_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_output_arbiter.sv
// Ring output-link arbiter: picks the ring or PE depth-1 buffer, reads it, and sends on one link.
// Define ARB_ROUND_ROBIN_EN for round-robin under contention; otherwise the ring has fixed priority.
module ring_output_arbiter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ring_full,
  output logic             ring_rd_en,
  input  logic [WIDTH-1:0] ring_data_in,
  input  logic             pe_full,
  output logic             pe_rd_en,
  input  logic [WIDTH-1:0] pe_data_in,
  output logic             so,
  input  logic             ro,
  output logic [WIDTH-1:0] data_out,
  output logic             grant_pe
);

  typedef enum logic [1:0] {StIdle, StFetch, StLoad, StSend} state_e;

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_pe_q, last_pe_d;
  logic             so_q, so_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             winner_pe;

`ifdef ARB_ROUND_ROBIN_EN
  // Under contention the side not served last wins.
  assign winner_pe = pe_full & (~ring_full | ~last_pe_q);
`else
  assign winner_pe = pe_full & ~ring_full;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      grant_q   <= 1'b0;
      last_pe_q <= 1'b1;
      so_q      <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_pe_q <= last_pe_d;
      so_q      <= so_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_pe_d = last_pe_q;
    so_d      = so_q;
    data_d    = data_q;
    unique case (state_q)
      StIdle: begin
        if (ring_full | pe_full) begin
          grant_d = winner_pe;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        // Buffer read data is registered, so it is valid one cycle after the read enable.
        data_d    = grant_q ? pe_data_in : ring_data_in;
        so_d      = 1'b1;
        last_pe_d = grant_q;
        state_d   = StSend;
      end
      StSend: begin
        if (so_q & ro) begin
          so_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ring_rd_en = 1'b0;
    pe_rd_en   = 1'b0;
    if (state_q == StFetch) begin
      ring_rd_en = ~grant_q;
      pe_rd_en   = grant_q;
    end
  end

  assign so       = so_q;
  assign data_out = data_q;
  assign grant_pe = grant_q;

endmodule

// File: tb/tb_ring_output_arbiter.sv
// Self-checking bench for ring_output_arbiter: depth-1 buffer models plus a timeline reference model.
module tb_ring_output_arbiter;
  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ring_full = 1'b0;
  logic         pe_full = 1'b0;
  logic         ro = 1'b0;
  logic [W-1:0] ring_data_in = '0;
  logic [W-1:0] pe_data_in = '0;
  logic         ring_rd_en, pe_rd_en, so, grant_pe;
  logic [W-1:0] data_out;

  always #5 clk = ~clk;

  ring_output_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .ring_full    (ring_full),
    .ring_rd_en   (ring_rd_en),
    .ring_data_in (ring_data_in),
    .pe_full      (pe_full),
    .pe_rd_en     (pe_rd_en),
    .pe_data_in   (pe_data_in),
    .so           (so),
    .ro           (ro),
    .data_out     (data_out),
    .grant_pe     (grant_pe)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Buffer contents held while the buffer is full.
  logic [W-1:0] ring_mem = '0;
  logic [W-1:0] pe_mem = '0;
  bit           auto_refill = 1'b0;
  bit           fixed_vals = 1'b0;
  int unsigned  refill_pct = 0;

  // Reference model: m_age counts edges since the arbitration decision (0 = no packet in flight).
  int           m_age = 0;
  bit           m_src = 1'b0;
  bit           m_last = 1'b1;
  bit           m_grant = 1'b0;
  logic [W-1:0] m_pkt = '0;
  logic [W-1:0] m_dout = '0;
  bit           exp_so = 1'b0, exp_ring_rd = 1'b0, exp_pe_rd = 1'b0, exp_grant = 1'b0;
  logic [W-1:0] exp_data = '0;

  task automatic update_exp();
    exp_so      = (m_age >= 3);
    exp_ring_rd = (m_age == 1) && !m_src;
    exp_pe_rd   = (m_age == 1) && m_src;
    exp_grant   = m_grant;
    exp_data    = m_dout;
  endtask

  task automatic model_reset();
    m_age = 0; m_last = 1'b1; m_grant = 1'b0; m_pkt = '0; m_dout = '0;
    update_exp();
  endtask

  // One clock: model decides from pre-edge inputs, buffers react to the DUT's read enables.
  task automatic cycle();
    bit rd_ring;
    bit rd_pe;
    if (m_age == 0) begin
      if (ring_full || pe_full) begin
        if (ring_full && pe_full) begin
`ifdef ARB_ROUND_ROBIN_EN
          m_src = !m_last;
`else
          m_src = 1'b0;
`endif
        end else begin
          m_src = pe_full;
        end
        m_pkt   = m_src ? pe_mem : ring_mem;
        m_grant = m_src;
        m_age   = 1;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (m_age == 2) begin
      m_age  = 3;
      m_dout = m_pkt;
      m_last = m_src;
    end else if (ro) begin
      m_age = 0;
    end
    rd_ring = ring_rd_en;
    rd_pe   = pe_rd_en;
    @(posedge clk);
    #1;
    if (rd_ring) begin ring_data_in = ring_mem; ring_full = 1'b0; end
    if (rd_pe)   begin pe_data_in = pe_mem;     pe_full = 1'b0;   end
    if (auto_refill) begin
      if (!ring_full && $urandom_range(99) < refill_pct) begin
        ring_mem  = fixed_vals ? 64'h1 : {$urandom, $urandom};
        ring_full = 1'b1;
      end
      if (!pe_full && $urandom_range(99) < refill_pct) begin
        pe_mem  = fixed_vals ? 64'h2 : {$urandom, $urandom};
        pe_full = 1'b1;
      end
    end
    update_exp();
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    auto_refill = 1'b0;
    ro = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      cycle();
      done = !ring_full && !pe_full && (m_age == 0);
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain: got busy after 60 cycles, want idle with empty buffers", tag);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_cmp += 5;
    if (so !== 1'b0) begin n_fail++; $display("FAIL reset_so: got %0b want 0", so); end
    if (data_out !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_out); end
    if (grant_pe !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %0b want 0", grant_pe); end
    if (ring_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_ring_rd: got %0b want 0", ring_rd_en); end
    if (pe_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_pe_rd: got %0b want 0", pe_rd_en); end
    reset = 1'b1;
  endtask

  task automatic test_single_ring();
    int rd_cnt = 0;
    ring_mem  = 64'hA5A5_0000_0000_0001;
    ring_full = 1'b1;
    ro        = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (ring_rd_en === 1'b1) rd_cnt++;
      n_cmp += 3;
      if (so !== exp_so) begin n_fail++; $display("FAIL single_so[%0d]: got %0b want %0b", i, so, exp_so); end
      if (data_out !== exp_data) begin
        n_fail++; $display("FAIL single_data[%0d]: got %h want %h", i, data_out, exp_data);
      end
      if (ring_rd_en !== exp_ring_rd) begin
        n_fail++; $display("FAIL single_ring_rd[%0d]: got %0b want %0b", i, ring_rd_en, exp_ring_rd);
      end
      if (i == 2) begin
        n_cmp += 3;
        if (so !== 1'b1) begin n_fail++; $display("FAIL single_so_edge3: got %0b want 1", so); end
        if (data_out !== 64'hA5A5_0000_0000_0001) begin
          n_fail++; $display("FAIL single_data_edge3: got %h want a5a5000000000001", data_out);
        end
        if (grant_pe !== 1'b0) begin n_fail++; $display("FAIL single_grant: got %0b want 0", grant_pe); end
      end
      if (i == 3) begin
        n_cmp++;
        if (so !== 1'b0) begin n_fail++; $display("FAIL single_so_drop: got %0b want 0", so); end
      end
    end
    n_cmp++;
    if (rd_cnt != 1) begin n_fail++; $display("FAIL single_rd_count: got %0d want 1", rd_cnt); end
  endtask

  task automatic test_backpressure();
    pe_mem  = 64'h1234;
    pe_full = 1'b1;
    ro      = 1'b0;
    repeat (3) cycle();
    for (int i = 0; i < 10; i++) begin
      n_cmp += 4;
      if (so !== 1'b1) begin n_fail++; $display("FAIL bp_so[%0d]: got %0b want 1", i, so); end
      if (data_out !== 64'h1234) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want 1234", i, data_out); end
      if ((ring_rd_en | pe_rd_en) !== 1'b0) begin
        n_fail++; $display("FAIL bp_rd_en[%0d]: got %0b/%0b want 0/0", i, ring_rd_en, pe_rd_en);
      end
      if (grant_pe !== 1'b1) begin n_fail++; $display("FAIL bp_grant[%0d]: got %0b want 1", i, grant_pe); end
      cycle();
    end
    ro = 1'b1;
    cycle();
    n_cmp += 2;
    if (so !== 1'b0) begin n_fail++; $display("FAIL bp_release_so: got %0b want 0", so); end
    if (data_out !== 64'h1234) begin n_fail++; $display("FAIL bp_release_data: got %h want 1234", data_out); end
    repeat (4) begin
      cycle();
      n_cmp++;
      if (so !== 1'b0) begin n_fail++; $display("FAIL bp_single_xfer: got so=%0b want 0", so); end
    end
  endtask

  task automatic test_contention();
    logic [W-1:0] got[$];
    logic [W-1:0] exp_seq[4];
    bit           prev_so = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{64'h1, 64'h2, 64'h1, 64'h2};
`else
    exp_seq = '{64'h1, 64'h1, 64'h1, 64'h1};
`endif
    ring_mem = 64'h1; ring_full = 1'b1;
    pe_mem = 64'h2; pe_full = 1'b1;
    ro = 1'b1; auto_refill = 1'b1; fixed_vals = 1'b1; refill_pct = 100;
    for (int i = 0; i < 40 && got.size() < 4; i++) begin
      cycle();
      if (so === 1'b1 && !prev_so) got.push_back(data_out);
      prev_so = (so === 1'b1);
    end
    n_cmp++;
    if (got.size() != 4) begin
      n_fail++; $display("FAIL contention_count: got %0d packets want 4", got.size());
    end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      n_cmp++;
      if (got[k] !== exp_seq[k]) begin
        n_fail++; $display("FAIL contention_seq[%0d]: got %h want %h", k, got[k], exp_seq[k]);
      end
    end
    drain("contention");
    fixed_vals = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_cmp += 3;
      if (so !== 1'b0) begin n_fail++; $display("FAIL idle_so[%0d]: got %0b want 0", i, so); end
      if (ring_rd_en !== 1'b0) begin n_fail++; $display("FAIL idle_ring_rd[%0d]: got %0b want 0", i, ring_rd_en); end
      if (pe_rd_en !== 1'b0) begin n_fail++; $display("FAIL idle_pe_rd[%0d]: got %0b want 0", i, pe_rd_en); end
    end
  endtask

  task automatic test_random();
    auto_refill = 1'b1; fixed_vals = 1'b0; refill_pct = 30;
    for (int i = 0; i < 400; i++) begin
      ro = 1'($urandom_range(1));
      cycle();
      n_cmp += 5;
      if (so !== exp_so) begin n_fail++; $display("FAIL rand_so[%0d]: got %0b want %0b", i, so, exp_so); end
      if (data_out !== exp_data) begin
        n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", i, data_out, exp_data);
      end
      if (grant_pe !== exp_grant) begin
        n_fail++; $display("FAIL rand_grant[%0d]: got %0b want %0b", i, grant_pe, exp_grant);
      end
      if (ring_rd_en !== exp_ring_rd) begin
        n_fail++; $display("FAIL rand_ring_rd[%0d]: got %0b want %0b", i, ring_rd_en, exp_ring_rd);
      end
      if (pe_rd_en !== exp_pe_rd) begin
        n_fail++; $display("FAIL rand_pe_rd[%0d]: got %0b want %0b", i, pe_rd_en, exp_pe_rd);
      end
    end
    drain("random");
  endtask

  task automatic test_async_reset();
    ring_mem  = 64'hDEAD_BEEF_0000_0077;
    ring_full = 1'b1;
    ro        = 1'b0;
    repeat (3) cycle();
    n_cmp++;
    if (so !== 1'b1) begin n_fail++; $display("FAIL areset_pre_so: got %0b want 1", so); end
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    n_cmp += 3;
    if (so !== 1'b0) begin n_fail++; $display("FAIL areset_so: got %0b want 0", so); end
    if (data_out !== '0) begin n_fail++; $display("FAIL areset_data: got %h want 0", data_out); end
    if (grant_pe !== 1'b0) begin n_fail++; $display("FAIL areset_grant: got %0b want 0", grant_pe); end
    ring_mem = 64'hAA; ring_full = 1'b1;
    pe_mem = 64'hBB; pe_full = 1'b1;
    #1;
    reset = 1'b1;
    ro = 1'b1;
    repeat (3) cycle();
    n_cmp += 3;
    if (so !== 1'b1) begin n_fail++; $display("FAIL areset_after_so: got %0b want 1", so); end
    if (data_out !== 64'hAA) begin n_fail++; $display("FAIL areset_after_data: got %h want aa", data_out); end
    if (grant_pe !== 1'b0) begin n_fail++; $display("FAIL areset_after_grant: got %0b want 0", grant_pe); end
    drain("areset");
  endtask

  initial begin
    test_reset();
    test_single_ring();
    test_backpressure();
    test_contention();
    test_idle();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
